// File: rtl/fsk_demodulate.sv
// FSK receiver: counts rising edges per bit window, decides each bit by edge
// frequency and reassembles an NBITS codeword (LSB first) with a valid strobe.
module fsk_demodulate #(
  parameter int OVERSAMPLE = 4,
  parameter int BIT_CLKS   = 64,
  parameter int NBITS      = 14,
  parameter int THRESH     = 6,
  parameter int MIN_EDGES  = 2,
  parameter int MAX_EDGES  = 11,
  parameter int ALIGN      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fsk,
  output logic [NBITS-1:0] Hamcode,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  localparam int AW = (ALIGN > 1) ? $clog2(ALIGN) : 1;
  localparam int WW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(BIT_CLKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NBITS - 1);
  localparam logic [3:0]    THR        = 4'(THRESH);
  localparam logic [3:0]    MIN_E      = 4'(MIN_EDGES);
  localparam logic [3:0]    MAX_E      = 4'(MAX_EDGES);

  // The bit window must span exactly 16 modulator clk2 periods.
  if (BIT_CLKS != 16 * OVERSAMPLE) begin : g_bad_window
    $error("BIT_CLKS must equal 16*OVERSAMPLE");
  end

  typedef enum logic {S_ALIGN, S_RUN} state_t;

  state_t           state, state_next;
  logic             sync_q, sync_qq, edge_q;
  logic [AW-1:0]    acnt;
  logic [WW-1:0]    wcnt;
  logic [3:0]       ecnt;
  logic [IW-1:0]    idx;
  logic [NBITS-1:0] shift;
  logic             ferr;

  logic             win_end;
  logic [3:0]       total;
  logic             bit_val;
  logic             sym_err;
  logic [NBITS-1:0] word;

  always_ff @(posedge clk) begin
    if (reset) state <= S_ALIGN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    win_end    = 1'b0;
    case (state)
      S_ALIGN: if (acnt == ALIGN_LAST) state_next = S_RUN;
      S_RUN:   win_end = (wcnt == WIN_LAST);
      default: state_next = S_ALIGN;
    endcase
  end

  // Decision includes an edge arriving in the window's last cycle.
  always_comb begin
    total   = (edge_q && ecnt != 4'hF) ? ecnt + 4'd1 : ecnt;
    bit_val = (total > THR);
    sym_err = (total < MIN_E) || (total > MAX_E);
    word    = shift;
    word[idx] = bit_val;
  end

  assign busy = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
      edge_q  <= 1'b0;
      acnt    <= '0;
      wcnt    <= '0;
      ecnt    <= '0;
      idx     <= '0;
      shift   <= '0;
      ferr    <= 1'b0;
      Hamcode <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      sync_q  <= fsk;
      sync_qq <= sync_q;
      edge_q  <= sync_q & ~sync_qq;
      valid   <= 1'b0;
      if (state == S_ALIGN) begin
        acnt <= acnt + 1'b1;
      end else if (win_end) begin
        wcnt       <= '0;
        ecnt       <= '0;
        shift[idx] <= bit_val;
        if (idx == IDX_LAST) begin
          idx     <= '0;
          ferr    <= 1'b0;
          Hamcode <= word;
          err     <= ferr | sym_err;
          valid   <= 1'b1;
        end else begin
          idx  <= idx + 1'b1;
          ferr <= ferr | sym_err;
        end
      end else begin
        wcnt <= wcnt + 1'b1;
        ecnt <= total;
      end
    end
  end

endmodule

// File: tb/tb_fsk_demodulate.sv
// Scoreboard bench for fsk_demodulate: a behavioural FSK source drives the line,
// a frame-level model predicts each codeword, a monitor checks every strobe.
module tb_fsk_demodulate;

  localparam int NBITS    = 14;
  localparam int BIT_CLKS = 64;
  localparam int ALIGN    = 3;
  localparam int FRAME    = NBITS * BIT_CLKS;

  typedef struct {
    logic [13:0] word;
    logic        err;
    int          cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fsk = 1'b0;
  logic [13:0] Hamcode;
  logic        valid, err, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  exp_t        sbq[$];
  logic [13:0] fw[8];
  int          fmode[8];   // 0 clean, 1 dead line, 2 noise burst on bit 5
  logic [13:0] held = '0;
  logic        hold_bad = 1'b0;

  fsk_demodulate #(
    .OVERSAMPLE(4), .BIT_CLKS(BIT_CLKS), .NBITS(NBITS),
    .THRESH(6), .MIN_EDGES(2), .MAX_EDGES(11), .ALIGN(ALIGN)
  ) dut (
    .clk(clk), .reset(reset), .fsk(fsk),
    .Hamcode(Hamcode), .valid(valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Modulator line at time m: '1' = 8 rising edges per window, '0' = 4.
  function automatic logic wave(input int m, input int n);
    int k, b, p;
    logic [13:0] w;
    k = m / FRAME;
    if (k >= n) k = n - 1;
    b = (m % FRAME) / BIT_CLKS;
    p = m % BIT_CLKS;
    w = fw[k];
    if (fmode[k] == 1) return 1'b0;
    if (fmode[k] == 2 && b == 5) return 1'(m % 2);
    if (w[b]) return 1'((p % 8) >= 4);
    return 1'((p % 16) >= 8);
  endfunction

  function automatic exp_t model(input int k, input int n);
    exp_t e;
    int   cnt, m;
    logic prev, cur;
    e.word  = '0;
    e.err   = 1'b0;
    e.cycle = ALIGN + FRAME * (k + 1);
    for (int b = 0; b < NBITS; b++) begin
      cnt = 0;
      for (int p = 0; p < BIT_CLKS; p++) begin
        m    = FRAME * k + BIT_CLKS * b + p;
        cur  = wave(m, n);
        prev = (m == 0) ? 1'b0 : wave(m - 1, n);
        if (cur && !prev) cnt++;
      end
      if (cnt > 15) cnt = 15;
      e.word[b] = (cnt > 6);
      if (cnt < 2 || cnt > 11) e.err = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (cyc == 0) held = '0;
    if (valid === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got strobe at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("hamcode", int'(Hamcode), int'(e.word));
        chk("err", int'(err), int'(e.err));
        chk("valid_cycle", cyc, e.cycle);
        chk("hold_between_strobes", int'(hold_bad), 0);
      end
      held     = Hamcode;
      hold_bad = 1'b0;
    end else if (cyc != 0 && Hamcode !== held) begin
      hold_bad = 1'b1;
    end
  end

  // Reset for rst_cycles, then play n frames; abort_bit >= 0 stops the last
  // frame partway through that bit and expects no strobe for it.
  task automatic play(input int n, input int rst_cycles, input int abort_bit);
    int abort_m, last_m, nexp;
    @(negedge clk);
    reset = 1'b1;
    fsk   = 1'($urandom);
    repeat (rst_cycles) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", int'({Hamcode, valid, err, busy}), 0);
      fsk = 1'($urandom);
    end
    nexp = (abort_bit >= 0) ? n - 1 : n;
    for (int k = 0; k < nexp; k++) sbq.push_back(model(k, n));
    abort_m = (abort_bit >= 0) ? FRAME * (n - 1) + BIT_CLKS * abort_bit + 20 : -1;
    last_m  = FRAME * n + 8;
    reset   = 1'b0;
    for (int m = 0; m <= last_m; m++) begin
      if (m == abort_m) break;
      fsk = wave(m, n);
      @(posedge clk);
      @(negedge clk);
      if (cyc == ALIGN - 1) chk("busy_before_align", int'(busy), 0);
      if (cyc == ALIGN)     chk("busy_after_align", int'(busy), 1);
    end
    chk("missing_valids", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      fw[k]    = '0;
      fmode[k] = 0;
    end

    for (int k = 0; k < 3; k++) fw[k] = 14'b10110011100101;
    play(3, 4, -1);

    fw[0] = 14'h3FFF;
    play(1, 2, -1);
    fw[0] = 14'h0000;
    play(1, 2, -1);

    fmode[0] = 1;
    fw[0]    = 14'($urandom);
    fw[1]    = 14'($urandom);
    play(2, 2, -1);
    fmode[0] = 0;

    fmode[0] = 2;
    fw[0]    = 14'($urandom) & ~14'h0020;
    fw[1]    = 14'($urandom);
    play(2, 2, -1);
    fmode[0] = 0;

    for (int k = 0; k < 4; k++) fw[k] = 14'($urandom);
    play(4, 2, -1);

    fw[0] = 14'($urandom) | 14'h0001;
    fw[1] = 14'($urandom);
    play(2, 2, 7);
    fw[0] = 14'($urandom);
    play(1, 1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
